// File: rtl/cru_pkg.sv
// Shared constants and helpers for the call/return sequencer.
package cru_pkg;

  // Default PC / return-address width; must match the stack data width.
  localparam int unsigned CruAw    = 8;
  localparam int unsigned CruDepth = 256;

  // Sequencer states.
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StPop  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;

  // Depth counter width: must hold the value DEPTH itself, not just DEPTH-1.
  function automatic int unsigned cru_depth_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int unsigned CruDepthW = cru_depth_w(CruDepth);

endpackage

// File: rtl/cru_depth_counter.sv
// Saturating stack-depth tracker; stands in for the full/empty flags the stack lacks.
module cru_depth_counter
  import cru_pkg::*;
#(
  parameter int unsigned DEPTH  = CruDepth,
  parameter int unsigned DepthW = cru_depth_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_i,
  input  logic              dec_i,
  output logic [DepthW-1:0] depth_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam logic [DepthW-1:0] MaxDepth = DepthW'(DEPTH);
  localparam logic [DepthW-1:0] One      = DepthW'(1);

  logic [DepthW-1:0] depth_q, depth_d;

  assign full_o  = (depth_q == MaxDepth);
  assign empty_o = (depth_q == '0);
  assign depth_o = depth_q;

  // Next depth: saturate at both ends even if the parent misbehaves.
  always_comb begin
    depth_d = depth_q;
    if (inc_i && !dec_i && !full_o) begin
      depth_d = depth_q + One;
    end else if (dec_i && !inc_i && !empty_o) begin
      depth_d = depth_q - One;
    end
  end

  // Depth register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

endmodule

// File: rtl/call_return_unit.sv
// Program counter and CALL/RET sequencer driving the upstream hardware stack.
module call_return_unit
  import cru_pkg::*;
#(
  parameter int unsigned AW     = CruAw,
  parameter int unsigned DEPTH  = CruDepth,
  parameter int unsigned DepthW = cru_depth_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_valid_i,
  input  logic              is_call_i,
  input  logic              is_ret_i,
  input  logic [AW-1:0]     call_target_i,
  input  logic [AW-1:0]     stk_data_i,
  output logic [AW-1:0]     pc_o,
  output logic              busy_o,
  output logic              stk_push_o,
  output logic              stk_pop_o,
  output logic [AW-1:0]     stk_value_o,
  output logic [DepthW-1:0] depth_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam logic [AW-1:0] PcOne = AW'(1);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] value_q, value_d;
  logic          push_q, push_d;
  logic          pop_q, pop_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic          depth_inc, depth_dec;
  logic          depth_full, depth_empty;
  logic [AW-1:0] pc_inc;

  // Both opcodes at once decodes as an ordinary instruction.
  logic do_call, do_ret;

  assign pc_inc  = pc_q + PcOne;
  assign do_call = inst_valid_i && is_call_i && !is_ret_i;
  assign do_ret  = inst_valid_i && is_ret_i && !is_call_i;

  cru_depth_counter #(
    .DEPTH  (DEPTH),
    .DepthW (DepthW)
  ) u_depth (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (depth_inc),
    .dec_i   (depth_dec),
    .depth_o (depth_o),
    .full_o  (depth_full),
    .empty_o (depth_empty)
  );

  // Next-state decode for the sequencer, PC and stack strobes.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    value_d   = value_q;
    push_d    = 1'b0;
    pop_d     = 1'b0;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    depth_inc = 1'b0;
    depth_dec = 1'b0;

    case (state_q)
      StIdle: begin
        if (do_call) begin
          if (!depth_full) begin
            push_d    = 1'b1;
            value_d   = pc_inc;
            pc_d      = call_target_i;
            depth_inc = 1'b1;
          end else begin
            ovf_d = 1'b1;
            pc_d  = pc_inc;
          end
        end else if (do_ret) begin
          if (!depth_empty) begin
            pop_d     = 1'b1;
            depth_dec = 1'b1;
            state_d   = StPop;
          end else begin
            unf_d = 1'b1;
            pc_d  = pc_inc;
          end
        end else if (inst_valid_i) begin
          pc_d = pc_inc;
        end
      end
      // Stack samples POP on the edge leaving this state.
      StPop: begin
        state_d = StWait;
      end
      // Popped return address is now on stk_data_i.
      StWait: begin
        pc_d    = stk_data_i;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Sequencer state, PC, strobes and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      value_q <= '0;
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      value_q <= value_d;
      push_q  <= push_d;
      pop_q   <= pop_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign pc_o        = pc_q;
  assign stk_push_o  = push_q;
  assign stk_pop_o   = pop_q;
  assign stk_value_o = value_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

endmodule

// File: tb/tb_call_return_unit.sv
// Directed bench for call_return_unit with a small behavioural stack model.
module tb_call_return_unit;

  localparam int unsigned AW     = 8;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned DepthW = 2;

  logic              clk;
  logic              rst;
  logic              inst_valid;
  logic              is_call;
  logic              is_ret;
  logic [AW-1:0]     call_target;
  logic [AW-1:0]     stk_data;
  logic [AW-1:0]     pc;
  logic              busy;
  logic              stk_push;
  logic              stk_pop;
  logic [AW-1:0]     stk_value;
  logic [DepthW-1:0] depth;
  logic              overflow;
  logic              underflow;

  int n_checks;
  int n_errors;

  call_return_unit #(
    .AW     (AW),
    .DEPTH  (DEPTH),
    .DepthW (DepthW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .inst_valid_i  (inst_valid),
    .is_call_i     (is_call),
    .is_ret_i      (is_ret),
    .call_target_i (call_target),
    .stk_data_i    (stk_data),
    .pc_o          (pc),
    .busy_o        (busy),
    .stk_push_o    (stk_push),
    .stk_pop_o     (stk_pop),
    .stk_value_o   (stk_value),
    .depth_o       (depth),
    .overflow_o    (overflow),
    .underflow_o   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stack: samples PUSH/POP on the edge after the strobe is set.
  logic [AW-1:0] mem [0:7];
  int            sp;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp       <= 0;
      stk_data <= '0;
    end else if (stk_push && sp < 8) begin
      mem[sp] <= stk_value;
      sp      <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      stk_data <= mem[sp-1];
      sp       <= sp - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic c, input logic r, input logic [AW-1:0] t);
    inst_valid  = v;
    is_call     = c;
    is_ret      = r;
    call_target = t;
  endtask

  task automatic plain(input int n);
    drive(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < n; i++) step();
    drive(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0);
    #3;
    check("rst_pc", 32'(pc), 32'h00);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_push", 32'(stk_push), 32'h0);
    check("rst_pop", 32'(stk_pop), 32'h0);
    check("rst_value", 32'(stk_value), 32'h00);
    check("rst_depth", 32'(depth), 32'h0);
    check("rst_flags", {30'h0, overflow, underflow}, 32'h0);
    #9 rst = 1'b0;

    // Plain instructions.
    drive(1'b1, 1'b0, 1'b0, '0);
    step(); check("plain_pc1", 32'(pc), 32'h01);
    step(); check("plain_pc2", 32'(pc), 32'h02);
    step(); check("plain_pc3", 32'(pc), 32'h03);
    check("plain_strobes", {30'h0, stk_push, stk_pop}, 32'h0);
    check("plain_depth", 32'(depth), 32'h0);
    drive(1'b0, 1'b0, 1'b0, '0);
    step(); check("idle_hold", 32'(pc), 32'h03);

    // CALL from 10 to 40.
    plain(13);
    check("pc_at_10", 32'(pc), 32'h10);
    drive(1'b1, 1'b1, 1'b0, 8'h40);
    step();
    check("call_push", 32'(stk_push), 32'h1);
    check("call_value", 32'(stk_value), 32'h11);
    check("call_pc", 32'(pc), 32'h40);
    check("call_depth", 32'(depth), 32'h1);
    check("call_busy", 32'(busy), 32'h0);
    drive(1'b0, 1'b0, 1'b0, '0);
    step();
    check("call_push_off", 32'(stk_push), 32'h0);

    // RET from 45 returns to 11; instruction held while busy.
    plain(5);
    check("pc_at_45", 32'(pc), 32'h45);
    drive(1'b1, 1'b0, 1'b1, '0);
    step();
    check("ret_pop", 32'(stk_pop), 32'h1);
    check("ret_busy1", 32'(busy), 32'h1);
    check("ret_depth", 32'(depth), 32'h0);
    check("ret_pc_frozen1", 32'(pc), 32'h45);
    step();
    check("ret_pop_off", 32'(stk_pop), 32'h0);
    check("ret_busy2", 32'(busy), 32'h1);
    check("ret_pc_frozen2", 32'(pc), 32'h45);
    step();
    drive(1'b0, 1'b0, 1'b0, '0);
    check("ret_pc", 32'(pc), 32'h11);
    check("ret_busy_off", 32'(busy), 32'h0);
    check("ret_no_unf", 32'(underflow), 32'h0);

    // Nested calls, overflow at DEPTH=2, then unwind.
    do_reset();
    plain(5);
    check("pc_at_05", 32'(pc), 32'h05);
    drive(1'b1, 1'b1, 1'b0, 8'h20);
    step();
    check("nest1_value", 32'(stk_value), 32'h06);
    check("nest1_depth", 32'(depth), 32'h1);
    drive(1'b0, 1'b0, 1'b0, '0);
    step();
    drive(1'b1, 1'b1, 1'b0, 8'h30);
    step();
    check("nest2_value", 32'(stk_value), 32'h21);
    check("nest2_pc", 32'(pc), 32'h30);
    check("nest2_depth", 32'(depth), 32'h2);
    drive(1'b0, 1'b0, 1'b0, '0);
    step();
    drive(1'b1, 1'b1, 1'b0, 8'h50);
    step();
    drive(1'b0, 1'b0, 1'b0, '0);
    check("ovf_push", 32'(stk_push), 32'h0);
    check("ovf_flag", 32'(overflow), 32'h1);
    check("ovf_pc", 32'(pc), 32'h31);
    check("ovf_depth", 32'(depth), 32'h2);
    check("ovf_value_held", 32'(stk_value), 32'h21);
    drive(1'b1, 1'b0, 1'b1, '0);
    step(); step(); step();
    drive(1'b0, 1'b0, 1'b0, '0);
    check("unwind1_pc", 32'(pc), 32'h21);
    check("unwind1_depth", 32'(depth), 32'h1);
    drive(1'b1, 1'b0, 1'b1, '0);
    step(); step(); step();
    drive(1'b0, 1'b0, 1'b0, '0);
    check("unwind2_pc", 32'(pc), 32'h06);
    check("unwind2_depth", 32'(depth), 32'h0);
    check("unwind_no_unf", 32'(underflow), 32'h0);
    check("ovf_sticky", 32'(overflow), 32'h1);

    // RET at depth 0 from 7F.
    plain(8'h79);
    check("pc_at_7f", 32'(pc), 32'h7f);
    drive(1'b1, 1'b0, 1'b1, '0);
    step();
    drive(1'b0, 1'b0, 1'b0, '0);
    check("unf_pop", 32'(stk_pop), 32'h0);
    check("unf_flag", 32'(underflow), 32'h1);
    check("unf_pc", 32'(pc), 32'h80);
    check("unf_busy", 32'(busy), 32'h0);

    // CALL and RET together act as a plain instruction.
    drive(1'b1, 1'b1, 1'b1, 8'h99);
    step();
    drive(1'b0, 1'b0, 1'b0, '0);
    check("both_pc", 32'(pc), 32'h81);
    check("both_strobes", {30'h0, stk_push, stk_pop}, 32'h0);
    check("both_busy", 32'(busy), 32'h0);

    // PC wraps FF -> 00.
    plain(8'h7e);
    check("pc_at_ff", 32'(pc), 32'hff);
    plain(1);
    check("pc_wrap", 32'(pc), 32'h00);

    // Reset during the WAIT state aborts the return.
    drive(1'b1, 1'b1, 1'b0, 8'h60);
    step();
    drive(1'b0, 1'b0, 1'b0, '0);
    step();
    drive(1'b1, 1'b0, 1'b1, '0);
    step(); step();
    check("wait_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    check("mid_rst_pc", 32'(pc), 32'h00);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_pop", 32'(stk_pop), 32'h0);
    check("mid_rst_depth", 32'(depth), 32'h0);
    check("mid_rst_flags", {30'h0, overflow, underflow}, 32'h0);
    drive(1'b0, 1'b0, 1'b0, '0);
    step();
    rst = 1'b0;
    step(); step();
    check("post_rst_pc", 32'(pc), 32'h00);
    check("post_rst_busy", 32'(busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Strobes must never overlap.
  always @(negedge clk) begin
    if (stk_push && stk_pop) begin
      n_errors++;
      $display("FAIL strobe_overlap: got push=1 pop=1 expected not both");
    end
  end

endmodule

// File: doc/call_return_unit.md
Name: call_return_unit

Overview:
Program-counter and call/return sequencer that drives the 8-bit hardware stack directly upstream of it.
- CALL: pushes return address (PC+1) onto the stack and jumps to the target.
- RET: pops the stack and loads PC with the popped value.
- Tracks stack depth itself and flags overflow/underflow, since the stack has no full/empty outputs.
- Sits between instruction decode and the stack; PC output feeds instruction fetch.

Parameters:
AW, 8, PC / return-address width; must equal stack data width.
DEPTH, 256, maximum number of stack entries the unit will push before flagging overflow.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset (shared with the stack)
inst_valid  in  1  decoded instruction present this cycle
is_call  in  1  instruction is CALL (qualified by inst_valid)
is_ret  in  1  instruction is RET (qualified by inst_valid)
call_target  in  AW  CALL destination address
stk_data  in  AW  stack read data (stack OUTPUT)
pc  out  AW  current program counter
busy  out  1  unit not accepting instructions (state != IDLE)
stk_push  out  1  stack PUSH strobe, registered, one cycle wide
stk_pop  out  1  stack POP strobe, registered, one cycle wide
stk_value  out  AW  stack VALUE, registered, held until next push
depth  out  clog2(DEPTH)+1  current entries on stack
overflow  out  1  sticky: CALL attempted at depth==DEPTH
underflow  out  1  sticky: RET attempted at depth==0

Behaviour:
- Reset (async, rst=1): all outputs 0 (pc, busy, stk_push, stk_pop, stk_value, depth, overflow, underflow), state=IDLE. Reset mid-RET aborts the return; no pc load occurs after release.
- States: IDLE, POP, WAIT. busy = (state != IDLE), combinational.
- IDLE, inst_valid=0: hold pc; strobes 0.
- IDLE, inst_valid=1, neither call nor ret: pc <= pc+1, modulo 2^AW (wraps FF→00).
- IDLE, CALL, depth<DEPTH, at edge N:
  - stk_push<=1, stk_value<=pc+1 (mod 2^AW), pc<=call_target, depth++.
  - stk_push returns to 0 at edge N+1. CALL completes in one cycle; busy stays 0.
- IDLE, CALL, depth==DEPTH: no push; overflow<=1; pc<=pc+1; depth unchanged.
- IDLE, RET, depth>0:
  - Edge N: stk_pop<=1, depth--, state<=POP.
  - Edge N+1: stk_pop<=0, state<=WAIT. The stack samples POP here; stk_data is valid after this edge.
  - Edge N+2: pc<=stk_data, state<=IDLE.
  - busy=1 during the two cycles after edge N.
- IDLE, RET, depth==0: no pop; underflow<=1; pc<=pc+1.
- is_call and is_ret both 1 with inst_valid: treated as plain instruction (pc+1), no stack access, no flag.
- While busy: inputs ignored. Upstream must hold the instruction and re-present it after busy falls. pc is frozen.
- stk_push and stk_pop are never both 1.
- Flags clear only on rst.
- depth never exceeds DEPTH and never goes below 0.

Decomposition:
- Shared package cru_pkg:
  - state enum {IDLE, POP, WAIT}
  - AW default constant
  - DEPTH_W = clog2(DEPTH)+1
- One natural sub-module: cru_depth_counter.
  - Inputs: inc, dec, rst.
  - Outputs: depth, full (depth==DEPTH), empty (depth==0).
  - Saturating; inc and dec never asserted together by the parent.
- Main FSM and PC register stay in call_return_unit.

Test Plan:
- Reset then 3 plain instructions -> pc 00→01→02→03; all strobes 0, depth=0.
- pc=10, CALL target=40 -> next cycle stk_push=1, stk_value=11, pc=40, depth=1; following cycle stk_push=0.
- After the CALL above, stack model returns 11: RET at pc=45 -> stk_pop=1 one cycle; busy=1 two cycles; pc=11 two edges after acceptance; depth=0.
- Nested CALL from 05 to 20 (push 06), CALL from 20 to 30 (push 21), RET, RET -> pc 21 then 06; depth 2→1→0; underflow=0.
- RET at depth=0 with pc=7F -> no stk_pop; underflow=1; pc=80. With DEPTH=2, a third CALL -> no push, overflow=1, pc+1.
- Assert rst during the RET WAIT state -> pc=00, busy=0, stk_pop=0, depth=0 immediately; no later pc load from stk_data.
